// File: rtl/exercise_1_pkg.sv
// Shared constants for the selectable unsigned divider: default width and pair-select codes.
package exercise_1_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        SEL_AB = 2'b00,
        SEL_BC = 2'b01,
        SEL_CD = 2'b10,
        SEL_DA = 2'b11
    } sel_e;

endpackage

// File: rtl/exercise_1_if.sv
// Operand/result bundle for the divider: four operands and a pair select in, quotient and error out.
interface exercise_1_if
    import exercise_1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [1:0]       select;
    logic [WIDTH-1:0] out;
    logic             error;

    modport master (
        output A, B, C, D, select,
        input  out, error
    );

    modport slave (
        input  A, B, C, D, select,
        output out, error
    );

endinterface

// File: rtl/exercise_1_restoring_divider.sv
// Combinational unsigned restoring divider: one shift/trial-subtract/restore row per quotient bit.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    logic [WIDTH-1:0] rem_row [WIDTH+1];

    assign rem_row[0] = '0;

    for (genvar r = 0; r < WIDTH; r++) begin : g_row
        logic [WIDTH-1:0] trial_low;
        logic             fits;

        // The bit shifted out of the partial remainder makes the trial value exceed any
        // WIDTH-bit divisor, so the subtraction always fits and wraps back into WIDTH bits.
        assign trial_low = {rem_row[r][WIDTH-2:0], dividend_i[WIDTH-1-r]};
        assign fits      = rem_row[r][WIDTH-1] | (trial_low >= divisor_i);

        assign quotient_o[WIDTH-1-r] = fits;
        assign rem_row[r+1]          = fits ? (trial_low - divisor_i) : trial_low;
    end

    assign remainder_o   = rem_row[WIDTH];
    assign div_by_zero_o = (divisor_i == '0);

endmodule

// File: rtl/exercise_1.sv
// Registered four-operand divider: picks a dividend/divisor pair, divides, and registers quotient and error.
module exercise_1
    import exercise_1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    exercise_1_if.slave bus
);

    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             error_d;
    logic             error_q;

    always_comb begin
        dividend = bus.A;
        divisor  = bus.B;
        case (sel_e'(bus.select))
            SEL_AB: begin dividend = bus.A; divisor = bus.B; end
            SEL_BC: begin dividend = bus.B; divisor = bus.C; end
            SEL_CD: begin dividend = bus.C; divisor = bus.D; end
            SEL_DA: begin dividend = bus.D; divisor = bus.A; end
            default: ;
        endcase
    end

    restoring_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .quotient_o    (out_d),
        .remainder_o   (),
        .div_by_zero_o (error_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            error_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            error_q <= error_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.error = error_q;

endmodule

// File: tb/tb_exercise_1.sv
// Scoreboard bench for exercise_1: predictor queues expected results per edge, monitor checks them one cycle later.
module tb_exercise_1;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exercise_1_if #(.WIDTH(W)) bus ();

    exercise_1 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    exp_t exp_q[$];

    // Reference: pair k divides operand k by operand k+1 (mod 4); zero divisor gives all ones.
    function automatic exp_t model(input logic r, input logic [1:0] s,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] ops [4];
        int unsigned  num, den;
        exp_t         e;
        ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
        num = ops[s];
        den = ops[(s + 1) % 4];
        if (r) begin
            e.q = '0; e.err = 1'b0;
        end else if (den == 0) begin
            e.q = {W{1'b1}}; e.err = 1'b1;
        end else begin
            e.q = W'(num / den); e.err = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_q.push_back(model(rst, bus.select, bus.A, bus.B, bus.C, bus.D));
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.out !== e.q) begin
                bad++;
                $display("FAIL out @%0t: got %0d expected %0d", $time, bus.out, e.q);
            end
            total++;
            if (bus.error !== e.err) begin
                bad++;
                $display("FAIL error @%0t: got %0b expected %0b", $time, bus.error, e.err);
            end
        end
    end

    task automatic apply(input logic r, input logic [1:0] s,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        @(negedge clk);
        rst        = r;
        bus.select = s;
        bus.A = a; bus.B = b; bus.C = c; bus.D = d;
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    function automatic logic [W-1:0] rnd_z();
        return ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
    endfunction

    initial begin
        rst = 1'b1;
        bus.select = 2'b00;
        bus.A = rnd(); bus.B = rnd(); bus.C = rnd(); bus.D = rnd();

        // reset with random operands, then first valid result
        apply(1, 2'b10, rnd(), rnd(), rnd(), rnd());
        apply(1, 2'b01, rnd(), rnd(), rnd(), rnd());
        apply(0, 2'b00, 8'd12, 8'd8, rnd(), rnd());

        // directed pairs and boundaries
        apply(0, 2'b01, rnd(), 8'd252, 8'd12, rnd());
        apply(0, 2'b10, rnd(), rnd(), 8'd128, 8'd12);
        apply(0, 2'b10, rnd(), rnd(), 8'd222, 8'd18);
        apply(0, 2'b00, 8'd87, 8'd202, rnd(), rnd());
        apply(0, 2'b01, rnd(), 8'd0, 8'd8, rnd());
        apply(0, 2'b11, 8'd0, rnd(), rnd(), 8'd12);
        apply(0, 2'b11, 8'd0, rnd(), rnd(), 8'd0);
        apply(0, 2'b01, rnd(), rnd(), 8'd0, 8'd0);
        apply(0, 2'b01, rnd(), 8'd77, 8'd5, 8'd0);
        apply(0, 2'b00, 8'd200, 8'd1, 8'd0, 8'd0);
        apply(0, 2'b10, 8'd0, 8'd0, 8'd255, 8'd255);

        // back-to-back select rotation
        for (int i = 0; i < 16; i++) begin
            apply(0, 2'(i), rnd_z(), rnd_z(), rnd_z(), rnd_z());
        end

        // mid-stream reset over a valid operand set
        apply(0, 2'b00, 8'd100, 8'd7, rnd(), rnd());
        apply(1, 2'b01, rnd(), 8'd90, 8'd9, rnd());
        apply(0, 2'b11, 8'd4, rnd(), rnd(), 8'd250);

        // randomized traffic with occasional zeros and resets
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 29) == 0), 2'($urandom), rnd_z(), rnd_z(), rnd_z(), rnd_z());
        end

        apply(0, 2'b00, 8'd9, 8'd3, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() > 1) begin
            bad++;
            $display("FAIL drain: got %0d pending expected at most 1", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
